axil_scratch_ram: RTL and testbench

- AXI4-Lite slave backing store that sits directly downstream of the JTAG-to-AXI bridge master port.
- It gives the debug host a word-addressed scratch memory with byte strobes.
- It returns SLVERR for out-of-range accesses.
- It is the default target behind the bridge for bring-up and for the bridge's own system-level tests.

---
 rtl/axil_pkg.sv | 22 ++
 rtl/axil_ram_array.sv | 46 ++++
 rtl/axil_scratch_ram.sv | 162 ++++++++++++++++
 tb/tb_axil_scratch_ram.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the scratch RAM slave.
//   resp_t       : AXI response encoding
//   AXIL_DATA_W  : supported data width (32 only)
//   AXIL_STRB_W  : byte-strobe width derived from the data width
//   range_resp() : maps a decode hit/miss onto OKAY/SLVERR
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    function automatic resp_t range_resp(input logic in_range);
        return in_range ? OKAY : SLVERR;
    endfunction

endpackage

// File: rtl/axil_ram_array.sv
// Simple dual-port synchronous RAM: one byte-enabled write port, one read
// port with 1-cycle latency. On a same-address collision the read returns
// the old contents. Kept standalone so an SRAM macro can replace it.
//   clk_i   : clock
//   we_i    : write enable
//   wbe_i   : per-byte write enables
//   waddr_i : write word index
//   wdata_i : write data
//   re_i    : read enable; rdata_o only changes when this is high
//   raddr_i : read word index
//   rdata_o : registered read data
module axil_ram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DATA_W/8-1:0]   wbe_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Non-blocking read and write in the same edge give read-before-write.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        for (int b = 0; b < STRB_W; b++) begin
            if (we_i && wbe_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_scratch_ram.sv
// AXI4-Lite scratch memory behind the JTAG-to-AXI bridge. Word-addressed
// RAM with byte strobes; accesses outside the window get SLVERR.
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   aw_*                   : write address channel
//   w_*                    : write data channel
//   b_*                    : write response channel
//   ar_*                   : read address channel
//   r_*                    : read data channel
module axil_scratch_ram
    import axil_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 17,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        DEPTH_WORDS    = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [31:0]               w_data_i,
    input  logic [3:0]                w_strb_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    output logic [1:0]                b_resp_o,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr_i,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    output logic [31:0]               r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_valid_o,
    input  logic                      r_ready_i
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // One extra bit so the window end can equal 2^AXI_ADDR_WIDTH.
    localparam logic [AXI_ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [AXI_ADDR_WIDTH:0] WIN_HI =
        WIN_LO + (AXI_ADDR_WIDTH+1)'(DEPTH_WORDS * 4);

    if (AXI_DATA_WIDTH != AXIL_DATA_W) begin : g_bad_data_width
        $error("axil_scratch_ram supports only 32-bit data");
    end
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) ||
        (IDX_W > AXI_ADDR_WIDTH - 2)) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of 2 that fits the address space");
    end

    function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH:0] ax;
        ax = {1'b0, a};
        return (ax >= WIN_LO) && (ax < WIN_HI);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    // Control state
    logic aw_full_q, aw_full_d;
    logic w_full_q,  w_full_d;
    logic b_valid_q, b_valid_d;
    logic r_valid_q, r_valid_d;

    // Payload registers, never reset
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]               w_data_q;
    logic [AXIL_STRB_W-1:0]    w_strb_q;
    resp_t                     b_resp_q;
    resp_t                     r_resp_q;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        commit;
    logic        wr_in_range, rd_in_range;
    logic [31:0] ram_rdata;

    // Readys/valids are forced low while reset is held.
    assign aw_ready_o = rst_ni & ~aw_full_q;
    assign w_ready_o  = rst_ni & ~w_full_q;
    assign ar_ready_o = rst_ni & ~r_valid_q;
    assign b_valid_o  = rst_ni & b_valid_q;
    assign r_valid_o  = rst_ni & r_valid_q;
    assign b_resp_o   = b_valid_o ? b_resp_q : OKAY;
    assign r_resp_o   = r_valid_o ? r_resp_q : OKAY;
    assign r_data_o   = (r_valid_o && (r_resp_q == OKAY)) ? ram_rdata : '0;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign w_hs  = w_valid_i  & w_ready_o;
    assign b_hs  = b_valid_o  & b_ready_i;
    assign ar_hs = ar_valid_i & ar_ready_o;
    assign r_hs  = r_valid_o  & r_ready_i;

    assign wr_in_range = addr_in_range(aw_addr_q);
    assign rd_in_range = addr_in_range(ar_addr_i);

    // A held pair only commits once the previous response has been taken.
    assign commit = rst_ni & aw_full_q & w_full_q & ~b_valid_q;

    // Handshake and commit/B-handshake terms are mutually exclusive per flag,
    // so the ordering below never masks an event.
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        b_valid_d = b_valid_q;
        r_valid_d = r_valid_q;
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_valid_d = 1'b1;
        end
        if (aw_hs) aw_full_d = 1'b1;
        if (w_hs)  w_full_d  = 1'b1;
        if (b_hs)  b_valid_d = 1'b0;
        if (r_hs)  r_valid_d = 1'b0;
        if (ar_hs) r_valid_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            b_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            b_valid_q <= b_valid_d;
            r_valid_q <= r_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (aw_hs)  aw_addr_q <= aw_addr_i;
        if (w_hs) begin
            w_data_q <= w_data_i;
            w_strb_q <= w_strb_i;
        end
        if (commit) b_resp_q <= range_resp(wr_in_range);
        if (ar_hs)  r_resp_q <= range_resp(rd_in_range);
    end

    axil_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (AXIL_DATA_W),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (commit & wr_in_range),
        .wbe_i   (w_strb_q),
        .waddr_i (word_index(aw_addr_q)),
        .wdata_i (w_data_q),
        .re_i    (ar_hs & rd_in_range),
        .raddr_i (word_index(ar_addr_i)),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_axil_scratch_ram.sv
module tb_axil_scratch_ram;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [16:0] aw_addr_i;
    logic        aw_valid_i;
    logic        aw_ready_o;
    logic [31:0] w_data_i;
    logic [3:0]  w_strb_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [1:0]  b_resp_o;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [16:0] ar_addr_i;
    logic        ar_valid_i;
    logic        ar_ready_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_valid_o;
    logic        r_ready_i;

    localparam logic [1:0] R_OK  = 2'b00;
    localparam logic [1:0] R_ERR = 2'b10;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    always #5 clk = ~clk;

    axil_scratch_ram dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .aw_addr_i  (aw_addr_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .b_resp_o   (b_resp_o),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .ar_addr_i  (ar_addr_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endfunction

    // Monitor: pops an expectation for every response handshake about to occur.
    logic [1:0]  mon_b;
    logic [33:0] mon_r;
    always @(negedge clk) begin
        if (b_valid_o && b_ready_i) begin
            if (b_q.size() == 0) begin
                chk("b_unexpected", 64'(b_valid_o), 64'(1'b0));
            end else begin
                mon_b = b_q.pop_front();
                chk("bresp", 64'(b_resp_o), 64'(mon_b));
            end
        end
        if (r_valid_o && r_ready_i) begin
            if (r_q.size() == 0) begin
                chk("r_unexpected", 64'(r_valid_o), 64'(1'b0));
            end else begin
                mon_r = r_q.pop_front();
                chk("rresp", 64'(r_resp_o), 64'(mon_r[33:32]));
                chk("rdata", 64'(r_data_o), 64'(mon_r[31:0]));
            end
        end
    end

    task automatic aw_send(input logic [16:0] a);
        int n = 0;
        aw_addr_i  = a;
        aw_valid_i = 1'b1;
        @(negedge clk);
        while (!aw_ready_o && n < 50) begin n++; @(negedge clk); end
        if (!aw_ready_o) timeout("aw_handshake");
        @(posedge clk); #1;
        aw_valid_i = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        w_data_i  = d;
        w_strb_i  = s;
        w_valid_i = 1'b1;
        @(negedge clk);
        while (!w_ready_o && n < 50) begin n++; @(negedge clk); end
        if (!w_ready_o) timeout("w_handshake");
        @(posedge clk); #1;
        w_valid_i = 1'b0;
    endtask

    // Also checks that RVALID is up right after the AR handshake edge.
    task automatic ar_send(input logic [16:0] a);
        int n = 0;
        ar_addr_i  = a;
        ar_valid_i = 1'b1;
        @(negedge clk);
        while (!ar_ready_o && n < 50) begin n++; @(negedge clk); end
        if (!ar_ready_o) timeout("ar_handshake");
        @(posedge clk); #1;
        ar_valid_i = 1'b0;
        chk("rvalid_latency", 64'(r_valid_o), 64'(1'b1));
    endtask

    task automatic wait_b_drain();
        int n = 0;
        @(negedge clk);
        while (b_q.size() != 0 && n < 100) begin n++; @(negedge clk); end
        if (b_q.size() != 0) timeout("b_drain");
        @(posedge clk); #1;
    endtask

    task automatic wait_r_drain();
        int n = 0;
        @(negedge clk);
        while (r_q.size() != 0 && n < 100) begin n++; @(negedge clk); end
        if (r_q.size() != 0) timeout("r_drain");
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [16:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        b_q.push_back(resp);
        fork
            aw_send(a);
            w_send(d, s);
        join
        wait_b_drain();
    endtask

    task automatic do_read(input logic [16:0] a, input logic [1:0] resp, input logic [31:0] d);
        r_q.push_back({resp, d});
        ar_send(a);
        wait_r_drain();
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name, {23'd0, aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o,
                   b_resp_o, r_resp_o, r_data_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        aw_addr_i = '0; aw_valid_i = 1'b0;
        w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
        ar_addr_i = '0; ar_valid_i = 1'b0;
        b_ready_i = 1'b1; r_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset_outputs");
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("readys_after_reset", {aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o}, 5'b11100);
        @(posedge clk); #1;

        // Full-word write then read back
        do_write(17'h00010, 32'hDEADBEEF, 4'hF, R_OK);
        do_read(17'h00010, R_OK, 32'hDEADBEEF);

        // Partial strobe merge
        do_write(17'h00020, 32'hAABBCCDD, 4'hF, R_OK);
        do_write(17'h00020, 32'h11223344, 4'b0101, R_OK);
        do_read(17'h00020, R_OK, 32'hAA22CC44);

        // W ahead of AW, B back-pressured, second pair held
        do_write(17'h00034, 32'h00000000, 4'hF, R_OK);
        b_ready_i = 1'b0;
        b_q.push_back(R_OK);
        w_send(32'hCAFE0001, 4'hF);
        repeat (3) begin
            @(negedge clk);
            chk("no_commit_before_aw", 64'(b_valid_o), 64'(1'b0));
            @(posedge clk); #1;
        end
        aw_send(17'h00030);
        @(posedge clk); #1;
        chk("b_after_commit", {b_valid_o, b_resp_o}, {1'b1, R_OK});
        b_q.push_back(R_OK);
        fork
            aw_send(17'h00034);
            w_send(32'h12345678, 4'hF);
        join
        chk("second_pair_held", {aw_ready_o, w_ready_o}, 2'b00);
        do_read(17'h00034, R_OK, 32'h00000000);
        repeat (5) begin
            @(negedge clk);
            chk("b_held", {b_valid_o, b_resp_o}, {1'b1, R_OK});
            @(posedge clk); #1;
        end
        b_ready_i = 1'b1;
        wait_b_drain();
        do_read(17'h00030, R_OK, 32'hCAFE0001);
        do_read(17'h00034, R_OK, 32'h12345678);

        // Out-of-range access
        do_write(17'h00000, 32'h0BADF00D, 4'hF, R_OK);
        do_write(17'h01000, 32'hFFFFFFFF, 4'hF, R_ERR);
        do_read(17'h01000, R_ERR, 32'h00000000);
        do_read(17'h00000, R_OK, 32'h0BADF00D);

        // Same-cycle write and read of word 7: read sees the old value
        do_write(17'h0001C, 32'h00000003, 4'hF, R_OK);
        b_q.push_back(R_OK);
        r_q.push_back({R_OK, 32'h00000003});
        w_send(32'h00000005, 4'hF);
        aw_addr_i  = 17'h0001C;
        aw_valid_i = 1'b1;
        @(posedge clk); #1;
        aw_valid_i = 1'b0;
        ar_send(17'h0001C);
        wait_b_drain();
        wait_r_drain();
        do_read(17'h0001C, R_OK, 32'h00000005);

        // Reset with a held W and a pending R
        do_write(17'h00024, 32'h00000077, 4'hF, R_OK);
        w_send(32'hEEEEEEEE, 4'hF);
        r_ready_i  = 1'b0;
        ar_addr_i  = 17'h00024;
        ar_valid_i = 1'b1;
        @(posedge clk); #1;
        ar_valid_i = 1'b0;
        chk("r_pending_before_reset", {r_valid_o, w_ready_o}, 2'b10);
        rst_ni = 1'b0;
        @(negedge clk);
        chk_reset_outs("mid_reset_outputs");
        @(posedge clk); #1;
        rst_ni    = 1'b1;
        r_ready_i = 1'b1;
        @(negedge clk);
        chk("readys_after_mid_reset", {aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o}, 5'b11100);
        @(posedge clk); #1;
        aw_send(17'h00024);
        repeat (4) begin
            @(negedge clk);
            chk("no_b_r_after_reset", {b_valid_o, r_valid_o}, 2'b00);
            @(posedge clk); #1;
        end
        do_read(17'h00024, R_OK, 32'h00000077);

        chk("b_queue_empty", 64'(b_q.size()), 64'd0);
        chk("r_queue_empty", 64'(r_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
